// File: rtl/fp_mac_pe_if.sv
// Operand/result bundle between a systolic-array controller (master) and one fp_mac_pe (slave).
interface fp_mac_pe_if #(
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int CNT_WIDTH = 8
);
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] Current_A;
  logic                  acc_clear;
  logic                  B_load;
  logic [DATA_WIDTH-1:0] Current_B;
  logic [DATA_WIDTH-1:0] Next_A;
  logic                  Next_valid;
  logic [DATA_WIDTH-1:0] PE_out;
  logic                  out_valid;
  logic [CNT_WIDTH-1:0]  mac_count;

  modport master (
    output in_valid, Current_A, acc_clear, B_load, Current_B,
    input  Next_A, Next_valid, PE_out, out_valid, mac_count
  );

  modport slave (
    input  in_valid, Current_A, acc_clear, B_load, Current_B,
    output Next_A, Next_valid, PE_out, out_valid, mac_count
  );
endinterface

// File: rtl/fp_mac_pe.sv
// Weight-stationary FP multiply-accumulate cell: stage 1 registers the RNE-rounded A*B,
// stage 2 accumulates it (RNE). A/valid are forwarded to the neighbouring PE after one cycle.
module fp_mac_pe #(
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int CNT_WIDTH = 8
) (
  input logic        clk,
  input logic        reset,
  fp_mac_pe_if.slave pe
);
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int E   = EXP_WIDTH;
  localparam int M   = MAN_WIDTH;
  localparam int D   = DATA_WIDTH;
  localparam int EW  = E + 3;
  localparam int PW  = 2 * (M + 1);
  localparam int AW  = M + 4;
  localparam int LZW = $clog2(AW + 1);

  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << E) - 1);
  localparam logic signed [EW-1:0] E_BIAS = EW'((1 << (E - 1)) - 1);

  localparam logic [D-1:0] POS_INF = {1'b0, {E{1'b1}}, {M{1'b0}}};

  logic [D-1:0]         next_a_q;
  logic                 next_valid_q;
  logic [D-1:0]         b_q;
  logic [D-1:0]         p1_prod_q;
  logic                 p1_valid_q;
  logic                 p1_clear_q;
  logic [D-1:0]         acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // ---------------- multiplier ----------------
  logic [E-1:0]           a_exp, b_exp;
  logic                   mul_sign;
  logic [PW-1:0]          mul_full;
  logic signed [EW-1:0]   mul_exp;
  logic [M-1:0]           mul_man;
  logic                   mul_g, mul_st;
  logic [M:0]             mul_rnd;
  logic [D-1:0]           mul_res;

  always_comb begin
    a_exp    = pe.Current_A[D-2 -: E];
    b_exp    = b_q[D-2 -: E];
    mul_sign = pe.Current_A[D-1] ^ b_q[D-1];
    mul_full = PW'({1'b1, pe.Current_A[M-1:0]}) * PW'({1'b1, b_q[M-1:0]});
    mul_exp  = $signed({3'b000, a_exp}) + $signed({3'b000, b_exp}) - E_BIAS;
    // product of two [1,2) significands lies in [1,4): at most one normalising shift
    if (mul_full[PW-1]) begin
      mul_man = mul_full[PW-2 -: M];
      mul_g   = mul_full[PW-2-M];
      mul_st  = |mul_full[PW-3-M:0];
      mul_exp = mul_exp + E_ONE;
    end else begin
      mul_man = mul_full[PW-3 -: M];
      mul_g   = mul_full[PW-3-M];
      mul_st  = |mul_full[PW-4-M:0];
    end
    mul_rnd = {1'b0, mul_man} + {{M{1'b0}}, mul_g & (mul_st | mul_man[0])};
    if (mul_rnd[M]) mul_exp = mul_exp + E_ONE;

    if (&a_exp || &b_exp)
      mul_res = {mul_sign, {E{1'b1}}, {M{1'b0}}};
    else if (a_exp == '0 || b_exp == '0)
      mul_res = {mul_sign, {(D-1){1'b0}}};
    else if (mul_exp >= E_MAX)
      mul_res = {mul_sign, {E{1'b1}}, {M{1'b0}}};
    else if (mul_exp <= E_ZERO)
      mul_res = {mul_sign, {(D-1){1'b0}}};
    else
      mul_res = {mul_sign, mul_exp[E-1:0], mul_rnd[M-1:0]};
  end

  // ---------------- adder ----------------
  logic [D-1:0]          add_x, add_y, big, sml;
  logic [E-1:0]          x_exp, y_exp, big_exp, sml_exp, shamt;
  logic                  x_inf, y_inf, x_zero, y_zero;
  logic [AW-1:0]         big_m, sml_m, sml_al;
  logic                  sml_lost;
  logic [AW:0]           add_sum;
  logic [AW-1:0]         add_dif, add_norm;
  logic [LZW-1:0]        add_lz;
  logic signed [EW-1:0]  add_exp;
  logic [M-1:0]          add_man;
  logic [M:0]            add_rnd;
  logic                  add_sub;
  logic [D-1:0]          add_res;

  always_comb begin
    add_x  = p1_clear_q ? '0 : acc_q;
    add_y  = p1_prod_q;
    x_exp  = add_x[D-2 -: E];
    y_exp  = add_y[D-2 -: E];
    x_inf  = &x_exp;
    y_inf  = &y_exp;
    x_zero = (x_exp == '0);
    y_zero = (y_exp == '0);

    if ({x_exp, add_x[M-1:0]} >= {y_exp, add_y[M-1:0]}) begin
      big = add_x;
      sml = add_y;
    end else begin
      big = add_y;
      sml = add_x;
    end
    big_exp = big[D-2 -: E];
    sml_exp = sml[D-2 -: E];
    shamt   = big_exp - sml_exp;
    add_sub = big[D-1] ^ sml[D-1];

    // three spare LSBs hold guard/round/sticky; everything shifted past them folds into bit 0
    big_m    = {1'b1, big[M-1:0], 3'b000};
    sml_m    = {1'b1, sml[M-1:0], 3'b000};
    sml_lost = |(sml_m & ~({AW{1'b1}} << shamt));
    sml_al   = (sml_m >> shamt) | {{(AW-1){1'b0}}, sml_lost};
    add_sum  = {1'b0, big_m} + {1'b0, sml_al};
    add_dif  = big_m - sml_al;

    add_lz = '0;
    for (int i = 0; i < AW; i++)
      if (add_dif[i]) add_lz = LZW'(AW - 1 - i);

    add_exp = $signed({3'b000, big_exp});
    if (!add_sub) begin
      if (add_sum[AW]) begin
        add_norm = add_sum[AW:1] | {{(AW-1){1'b0}}, add_sum[0]};
        add_exp  = add_exp + E_ONE;
      end else begin
        add_norm = add_sum[AW-1:0];
      end
    end else begin
      add_norm = add_dif << add_lz;
      add_exp  = add_exp - $signed({{(EW-LZW){1'b0}}, add_lz});
    end

    add_man = add_norm[AW-2 -: M];
    add_rnd = {1'b0, add_man} + {{M{1'b0}}, add_norm[2] & ((|add_norm[1:0]) | add_man[0])};
    if (add_rnd[M]) add_exp = add_exp + E_ONE;

    if (x_inf && y_inf && (add_x[D-1] != add_y[D-1]))
      add_res = POS_INF;
    else if (x_inf)
      add_res = {add_x[D-1], {E{1'b1}}, {M{1'b0}}};
    else if (y_inf)
      add_res = {add_y[D-1], {E{1'b1}}, {M{1'b0}}};
    else if (x_zero && y_zero)
      add_res = {add_x[D-1] & add_y[D-1], {(D-1){1'b0}}};
    else if (x_zero)
      add_res = add_y;
    else if (y_zero)
      add_res = add_x;
    else if (add_sub && add_dif == '0)
      add_res = '0;
    else if (add_exp >= E_MAX)
      add_res = {big[D-1], {E{1'b1}}, {M{1'b0}}};
    else if (add_exp <= E_ZERO)
      add_res = {big[D-1], {(D-1){1'b0}}};
    else
      add_res = {big[D-1], add_exp[E-1:0], add_rnd[M-1:0]};
  end

  // ---------------- accumulator / count ----------------
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    if (p1_valid_q) begin
      acc_d       = add_res;
      out_valid_d = 1'b1;
      if (p1_clear_q)
        cnt_d = CNT_WIDTH'(1);
      else if (cnt_q != '1)
        cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (p1_clear_q) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_a_q     <= '0;
      next_valid_q <= 1'b0;
      b_q          <= '0;
      p1_prod_q    <= '0;
      p1_valid_q   <= 1'b0;
      p1_clear_q   <= 1'b0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      next_a_q     <= pe.Current_A;
      next_valid_q <= pe.in_valid;
      if (pe.B_load) b_q <= pe.Current_B;
      p1_prod_q    <= mul_res;
      p1_valid_q   <= pe.in_valid;
      p1_clear_q   <= pe.acc_clear;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pe.Next_A     = next_a_q;
  assign pe.Next_valid = next_valid_q;
  assign pe.PE_out     = acc_q;
  assign pe.out_valid  = out_valid_q;
  assign pe.mac_count  = cnt_q;
endmodule

// File: tb/tb_fp_mac_pe.sv
// Bench for fp_mac_pe: directed FP16 cases plus random streams, checked against a
// real-arithmetic reference model with exact sums and explicit round-to-nearest-even.
module tb_fp_mac_pe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fp_mac_pe_if pe_if ();

  fp_mac_pe dut (
    .clk   (clk),
    .reset (reset),
    .pe    (pe_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          v;
    bit          c;
    logic [15:0] p;
  } item_t;

  item_t       q[$];
  logic [15:0] m_b;
  logic [15:0] m_acc;
  int          m_cnt;
  bit          m_ov;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_mag(input logic [15:0] x);
    if (x[14:10] == 5'd0) return 0.0;
    return (1.0 + real'(x[9:0]) / 1024.0) * pow2(int'(x[14:10]) - 15);
  endfunction

  function automatic logic [15:0] fp_round(input real mag, input logic s);
    real m, frac, rem;
    int  e, f;
    logic [4:0] ef;
    logic [9:0] mf;
    m = mag;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    frac = (m - 1.0) * 1024.0;
    f    = int'($floor(frac));
    rem  = frac - real'(f);
    if (rem > 0.5 || (rem == 0.5 && f[0])) f++;
    if (f == 1024) begin f = 0; e++; end
    e = e + 15;
    if (e >= 31) return {s, 5'h1f, 10'h000};
    if (e <= 0)  return {s, 15'h0000};
    ef = 5'(e);
    mf = 10'(f);
    return {s, ef, mf};
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    s = a[15] ^ b[15];
    if (&a[14:10] || &b[14:10]) return {s, 5'h1f, 10'h000};
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'h0000};
    return fp_round(fp_mag(a) * fp_mag(b), s);
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] x, input logic [15:0] y);
    real v;
    bit  xi, yi, xz, yz;
    xi = &x[14:10];
    yi = &y[14:10];
    xz = (x[14:10] == 5'd0);
    yz = (y[14:10] == 5'd0);
    if (xi && yi && x[15] != y[15]) return 16'h7c00;
    if (xi) return {x[15], 5'h1f, 10'h000};
    if (yi) return {y[15], 5'h1f, 10'h000};
    if (xz && yz) return {x[15] & y[15], 15'h0000};
    if (xz) return y;
    if (yz) return x;
    v = (x[15] ? -fp_mag(x) : fp_mag(x)) + (y[15] ? -fp_mag(y) : fp_mag(y));
    if (v == 0.0) return 16'h0000;
    if (v < 0.0) return fp_round(-v, 1'b1);
    return fp_round(v, 1'b0);
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 15) != 0) r[14:10] = 5'($urandom_range(8, 22));
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic check_outputs(input logic [15:0] a, input bit v);
    check_eq("next_a",     pe_if.Next_A,     a);
    check_eq("next_valid", pe_if.Next_valid, v);
    check_eq("out_valid",  pe_if.out_valid,  m_ov);
    check_eq("pe_out",     pe_if.PE_out,     m_acc);
    check_eq("mac_count",  pe_if.mac_count,  m_cnt);
  endtask

  task automatic step(input bit v, input logic [15:0] a, input bit clr,
                      input bit bl, input logic [15:0] b);
    item_t it;
    pe_if.in_valid  = v;
    pe_if.Current_A = a;
    pe_if.acc_clear = clr;
    pe_if.B_load    = bl;
    pe_if.Current_B = b;
    it.v = v;
    it.c = clr;
    it.p = m_mul(a, m_b);
    q.push_back(it);
    if (bl) m_b = b;
    @(posedge clk);
    #1;
    m_ov = 1'b0;
    if (q.size() == 2) begin
      it = q.pop_front();
      if (it.v) begin
        m_acc = m_add(it.c ? 16'h0000 : m_acc, it.p);
        m_cnt = it.c ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
        m_ov  = 1'b1;
      end else if (it.c) begin
        m_acc = 16'h0000;
        m_cnt = 0;
      end
    end
    check_outputs(a, v);
  endtask

  task automatic do_reset(input int cycles);
    reset           = 1'b1;
    pe_if.in_valid  = 1'b1;
    pe_if.Current_A = 16'h1234;
    pe_if.acc_clear = 1'b0;
    pe_if.B_load    = 1'b1;
    pe_if.Current_B = 16'h3c00;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_b   = 16'h0000;
    m_acc = 16'h0000;
    m_cnt = 0;
    m_ov  = 1'b0;
    check_eq("rst_next_a",     pe_if.Next_A,     16'h0000);
    check_eq("rst_next_valid", pe_if.Next_valid, 1'b0);
    check_eq("rst_pe_out",     pe_if.PE_out,     16'h0000);
    check_eq("rst_out_valid",  pe_if.out_valid,  1'b0);
    check_eq("rst_mac_count",  pe_if.mac_count,  8'd0);
  endtask

  initial begin
    pe_if.in_valid  = 1'b0;
    pe_if.Current_A = '0;
    pe_if.acc_clear = 1'b0;
    pe_if.B_load    = 1'b0;
    pe_if.Current_B = '0;

    check_eq("model_tie", m_mul(16'h459a, 16'h4200), 16'h4c34);
    do_reset(2);
    step(0, 16'h0000, 0, 0, 16'h0000);

    // 3.0 weight, short accumulation including a tie-to-even product
    step(0, 16'h0000, 0, 1, 16'h4200);
    step(1, 16'h4000, 1, 0, 16'h0000);
    step(1, 16'h459a, 0, 0, 16'h0000);
    check_eq("tp_first",     pe_if.PE_out,    16'h4600);
    check_eq("tp_first_ov",  pe_if.out_valid, 1'b1);
    check_eq("tp_first_cnt", pe_if.mac_count, 8'd1);
    step(1, 16'hc866, 0, 0, 16'h0000);
    check_eq("tp_tie",     pe_if.PE_out,    16'h4db4);
    check_eq("tp_tie_cnt", pe_if.mac_count, 8'd2);
    step(0, 16'h0000, 0, 0, 16'h0000);
    check_eq("tp_neg",     pe_if.PE_out,    16'hc328);
    check_eq("tp_neg_cnt", pe_if.mac_count, 8'd3);
    step(0, 16'h0000, 0, 0, 16'h0000);

    // weight load in the same cycle as a sample: old weight applies
    step(1, 16'h3c00, 1, 1, 16'h4400);
    step(1, 16'h3c00, 1, 0, 16'h0000);
    check_eq("old_b", pe_if.PE_out, 16'h4200);
    step(0, 16'h0000, 0, 0, 16'h0000);
    check_eq("new_b", pe_if.PE_out, 16'h4400);

    // clear without a sample
    step(0, 16'h5555, 1, 0, 16'h0000);
    step(0, 16'h0000, 0, 0, 16'h0000);
    check_eq("bare_clear",     pe_if.PE_out,    16'h0000);
    check_eq("bare_clear_ov",  pe_if.out_valid, 1'b0);
    check_eq("bare_clear_cnt", pe_if.mac_count, 8'd0);

    // overflow to +Inf
    step(0, 16'h0000, 0, 1, 16'h7bff);
    step(1, 16'h7bff, 1, 0, 16'h0000);
    step(0, 16'h0000, 0, 0, 16'h0000);
    check_eq("overflow", pe_if.PE_out, 16'h7c00);

    // reset with samples in flight
    step(1, 16'h3c00, 1, 0, 16'h0000);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0000, 0, 0, 16'h0000);
      check_eq("flush_ov", pe_if.out_valid, 1'b0);
    end

    // mac_count saturation with a zero weight
    step(0, 16'h0000, 0, 1, 16'h0000);
    step(1, rand_fp(), 1, 0, 16'h0000);
    for (int i = 0; i < 262; i++) step(1, rand_fp(), 0, 0, 16'h0000);
    step(0, 16'h0000, 0, 0, 16'h0000);
    check_eq("cnt_sat", pe_if.mac_count, 8'hff);

    // random streams
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_fp(), $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, rand_fp());
    step(0, 16'h0000, 0, 0, 16'h0000);
    step(0, 16'h0000, 0, 0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
